// File: rtl/decoded_inst_queue.sv
//------------------------------------------------------------------------------
// decoded_inst_queue
//
// In-order buffer between the format-specific instruction decoders and the
// rename/dispatch stage. Decoded instructions are written once per cycle when
// the decoders present them and are offered to the consumer in arrival order
// with first-word-fall-through timing. The payload is never inspected.
//
// The decoders register their output, so one more instruction can arrive
// after they see stall_o. stall_o therefore asserts while SKID slots are
// still free. It is registered from the next-cycle occupancy.
//
// Optional build feature:
//   DECODE_QUEUE_HWM_EN  adds hwm_o. This is the peak occupancy since the
//                        last reset or flush.
//
// Ports:
//   clock_i     in   1        rising-edge clock
//   reset_i     in   1        asynchronous reset, active low
//   flush_i     in   1        synchronous discard of all entries; beats push/pop
//   enable_i    in   1        decoder output valid (push request)
//   entry_i     in   ENTRY_W  packed decoded instruction
//   stall_o     out  1        to decoders: occupancy >= DEPTH-SKID
//   valid_o     out  1        head entry valid
//   entry_o     out  ENTRY_W  head entry payload, zero when empty
//   ready_i     in   1        consumer takes the head when valid_o=1
//   count_o     out  PTR_W+1  occupancy, 0..DEPTH
//   overflow_o  out  1        sticky: push dropped because queue was full
//   hwm_o       out  PTR_W+1  peak occupancy (DECODE_QUEUE_HWM_EN only)
//
// Payload packing, most significant field first:
//   opcode(12) address(64) funcUnit(3) majId(64) minId(5) numMicroOps(5)
//   is64Bit(1) pid(20) tid(16) op1rw(2) op2rw(2) op1isReg op2isReg
//   immIsExtended immIsShifted modifiesCR (1 each) body(26)  = 225 bits
//------------------------------------------------------------------------------
module decoded_inst_queue #(
   parameter int DEPTH   = 8,
   parameter int PTR_W   = 3,
   parameter int SKID    = 2,
   parameter int ENTRY_W = 225
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               flush_i,
   input  logic               enable_i,
   input  logic [ENTRY_W-1:0] entry_i,
   output logic               stall_o,
   output logic               valid_o,
   output logic [ENTRY_W-1:0] entry_o,
   input  logic               ready_i,
   output logic [PTR_W:0]     count_o,
   output logic               overflow_o
`ifdef DECODE_QUEUE_HWM_EN
   ,
   output logic [PTR_W:0]     hwm_o
`endif
);

   // Occupancy thresholds, sized to the counter so compares are width-exact.
   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_STALL = (PTR_W+1)'(DEPTH - SKID);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = (PTR_W)'(1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             valid_q,  valid_d;
   logic             stall_q,  stall_d;
   logic             overflow_q, overflow_d;

   logic full;
   logic pop;
   logic push_ok;

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      full    = (count_q == CNT_FULL);
      pop     = valid_q & ready_i;
      // A pop in the same cycle frees a slot, so a push into a full queue is
      // still accepted then.
      push_ok = enable_i & (~full | pop);

      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         // The pointers are exactly log2(DEPTH) wide, so they wrap naturally.
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

         unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase

         if (enable_i && full && !pop) overflow_d = 1'b1;
      end

      // These flags are registered from the next count. They then line up
      // with count_o on the same edge.
      valid_d = (count_d != '0);
      stall_d = (count_d >= CNT_STALL);
   end

   //---------------------------------------------------------------------------
   // Control state
   //---------------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge reset_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      if (!reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         stall_q    <= stall_d;
         overflow_q <= overflow_d;
      end
   end

   //---------------------------------------------------------------------------
   // Payload storage
   //---------------------------------------------------------------------------
   // NOTE: the storage array has no reset. valid_q gates every read, so stale
   // contents are never visible, and the array can map to plain RAM/flops
   // without reset wiring.
   always_ff @(posedge clock_i) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= entry_i;
   end

   // Fall-through head. Zero forcing when empty also covers the asynchronous
   // reset, because valid_q clears at once.
   assign entry_o    = valid_q ? mem_q[rd_ptr_q] : '0;
   assign valid_o    = valid_q;
   assign stall_o    = stall_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

`ifdef DECODE_QUEUE_HWM_EN
   //---------------------------------------------------------------------------
   // High-water mark: tracks count_d, so it moves on the same edge as count.
   //---------------------------------------------------------------------------
   logic [PTR_W:0] hwm_q, hwm_d;

   always_comb begin
      hwm_d = hwm_q;
      if (flush_i)              hwm_d = '0;
      else if (count_d > hwm_q) hwm_d = count_d;
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) hwm_q <= '0;
      else          hwm_q <= hwm_d;
   end

   assign hwm_o = hwm_q;
`endif

   //---------------------------------------------------------------------------
   // Structural invariants
   //---------------------------------------------------------------------------
   a_count_bound: assert property (@(posedge clock_i) disable iff (!reset_i)
      count_q <= CNT_FULL);
   a_valid_tracks_count: assert property (@(posedge clock_i) disable iff (!reset_i)
      valid_q == (count_q != '0));

endmodule

// File: tb/tb_decoded_inst_queue.sv
//------------------------------------------------------------------------------
// tb_decoded_inst_queue
//
// Self-checking bench for decoded_inst_queue. A queue-based reference model
// predicts the visible state. A compare process checks every output against
// it on each falling edge. Directed scenarios add literal expectations. A
// randomized phase follows them.
//------------------------------------------------------------------------------
module tb_decoded_inst_queue;

   localparam int DEPTH   = 8;
   localparam int PTR_W   = 3;
   localparam int SKID    = 2;
   localparam int ENTRY_W = 225;

   typedef struct packed {
      logic [11:0] opcode;
      logic [63:0] address;
      logic [2:0]  func_unit;
      logic [63:0] maj_id;
      logic [4:0]  min_id;
      logic [4:0]  num_micro_ops;
      logic        is_64bit;
      logic [19:0] pid;
      logic [15:0] tid;
      logic [1:0]  op1rw;
      logic [1:0]  op2rw;
      logic        op1_is_reg;
      logic        op2_is_reg;
      logic        imm_is_extended;
      logic        imm_is_shifted;
      logic        modifies_cr;
      logic [25:0] body;
   } entry_t;

   logic               clock_i;
   logic               reset_i;
   logic               flush_i;
   logic               enable_i;
   logic [ENTRY_W-1:0] entry_i;
   logic               stall_o;
   logic               valid_o;
   logic [ENTRY_W-1:0] entry_o;
   logic               ready_i;
   logic [PTR_W:0]     count_o;
   logic               overflow_o;
`ifdef DECODE_QUEUE_HWM_EN
   logic [PTR_W:0]     hwm_o;
`endif

   decoded_inst_queue #(
      .DEPTH(DEPTH), .PTR_W(PTR_W), .SKID(SKID), .ENTRY_W(ENTRY_W)
   ) dut (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .flush_i    (flush_i),
      .enable_i   (enable_i),
      .entry_i    (entry_i),
      .stall_o    (stall_o),
      .valid_o    (valid_o),
      .entry_o    (entry_o),
      .ready_i    (ready_i),
      .count_o    (count_o),
      .overflow_o (overflow_o)
`ifdef DECODE_QUEUE_HWM_EN
      ,
      .hwm_o      (hwm_o)
`endif
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model: an ordered list of accepted instructions
   //---------------------------------------------------------------------------
   logic [ENTRY_W-1:0] m_q [$];
   bit                 m_ovf;
   int                 m_hwm;
   bit                 m_pop;
   bit                 m_full;

   always @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_hwm = 0;
      end else if (flush_i) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_hwm = 0;
      end else begin
         m_pop  = (m_q.size() != 0) && ready_i;
         m_full = (m_q.size() == DEPTH);
         if (m_pop) void'(m_q.pop_front());
         if (enable_i) begin
            if (m_full && !m_pop) m_ovf = 1'b1;
            else                  m_q.push_back(entry_i);
         end
         if (m_q.size() > m_hwm) m_hwm = m_q.size();
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock_i) begin
      if (reset_i) begin
         check("cmp_valid",    valid_o,    (m_q.size() != 0));
         check("cmp_entry",    entry_o,    (m_q.size() != 0) ? m_q[0] : '0);
         check("cmp_count",    count_o,    m_q.size());
         check("cmp_stall",    stall_o,    (m_q.size() >= DEPTH - SKID));
         check("cmp_overflow", overflow_o, m_ovf);
`ifdef DECODE_QUEUE_HWM_EN
         check("cmp_hwm",      hwm_o,      m_hwm);
`endif
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   function automatic logic [ENTRY_W-1:0] rand_entry();
      logic [255:0] w;
      w = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      return w[ENTRY_W-1:0];
   endfunction

   function automatic logic [ENTRY_W-1:0] mk_entry(input logic [11:0] opc, input logic [63:0] maj);
      entry_t e;
      e        = rand_entry();
      e.opcode = opc;
      e.maj_id = maj;
      return e;
   endfunction

   function automatic logic [63:0] maj_of(input logic [ENTRY_W-1:0] v);
      entry_t e;
      e = v;
      return e.maj_id;
   endfunction

   // Drive inputs just after a falling edge, run one rising edge, and return
   // at the next falling edge.
   task automatic cycle(input logic en, input logic rdy, input logic fl,
                        input logic [ENTRY_W-1:0] ent);
      enable_i = en;
      ready_i  = rdy;
      flush_i  = fl;
      entry_i  = ent;
      @(posedge clock_i);
      @(negedge clock_i);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   //---------------------------------------------------------------------------
   // Directed scenarios followed by random traffic
   //---------------------------------------------------------------------------
   logic [ENTRY_W-1:0] e1;

   initial begin
      reset_i  = 1'b0;
      flush_i  = 1'b0;
      enable_i = 1'b0;
      ready_i  = 1'b0;
      entry_i  = '0;
      #1;
      check("rst_valid",    valid_o,    0);
      check("rst_count",    count_o,    0);
      check("rst_entry",    entry_o,    0);
      check("rst_stall",    stall_o,    0);
      check("rst_overflow", overflow_o, 0);
      @(negedge clock_i);
      @(negedge clock_i);
      reset_i = 1'b1;

      // Single push, then pop.
      e1 = mk_entry(12'h0E0, 64'd5);
      cycle(1'b1, 1'b0, 1'b0, e1);
      check("t1_valid",  valid_o, 1);
      check("t1_entry",  entry_o, e1);
      check("t1_majid",  maj_of(entry_o), 5);
      check("t1_count",  count_o, 1);
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("t1_pop_valid", valid_o, 0);
      check("t1_pop_count", count_o, 0);

      // Fill with stall and overflow boundaries.
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, 1'b0, mk_entry(12'h100, 64'(i)));
         if (i == 4) check("t2_stall_at5", stall_o, 0);
      end
      check("t2_stall_at6", stall_o, 1);
      cycle(1'b1, 1'b0, 1'b0, mk_entry(12'h100, 64'd6));
      cycle(1'b1, 1'b0, 1'b0, mk_entry(12'h100, 64'd7));
      check("t2_count_full", count_o, 8);
      check("t2_no_ovf",     overflow_o, 0);
      cycle(1'b1, 1'b0, 1'b0, mk_entry(12'h100, 64'd8));
      check("t2_ovf",        overflow_o, 1);
      check("t2_count_held", count_o, 8);
      check("t2_head_kept",  maj_of(entry_o), 0);

      // Push and pop together while full.
      check("t3_head_oldest", maj_of(entry_o), 0);
      cycle(1'b1, 1'b1, 1'b0, mk_entry(12'h100, 64'd9));
      check("t3_count", count_o, 8);
      check("t3_next_head", maj_of(entry_o), 1);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, '0);
      check("t3_last_majid", maj_of(entry_o), 9);
      check("t3_last_count", count_o, 1);
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("t3_empty", valid_o, 0);
      cycle(1'b0, 1'b0, 1'b1, '0);
      check("t3_flush_ovf", overflow_o, 0);

      // Continuous streaming through two pointer wraps.
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 1'b0, mk_entry(12'h200, 64'(i)));
         check("t4_majid", maj_of(entry_o), 64'(i));
         check("t4_count", count_o, 1);
      end
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("t4_drained", count_o, 0);

      // Flush beats a concurrent push and pop.
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, mk_entry(12'h300, 64'(i)));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0);
      check("t5_pre_count", count_o, 5);
      check("t5_pre_ovf",   overflow_o, 1);
      cycle(1'b1, 1'b1, 1'b1, mk_entry(12'h300, 64'd99));
      check("t5_count", count_o, 0);
      check("t5_valid", valid_o, 0);
      check("t5_ovf",   overflow_o, 0);
      check("t5_stall", stall_o, 0);
      idle();
      check("t5_push_dropped", count_o, 0);

      // Asynchronous reset between edges.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, mk_entry(12'h400, 64'(i)));
      enable_i = 1'b0;
      check("t6_pre_count", count_o, 3);
`ifdef DECODE_QUEUE_HWM_EN
      check("t6_pre_hwm", hwm_o, 3);
`endif
      #2;
      reset_i = 1'b0;
      #1;
      check("t6_valid",    valid_o,    0);
      check("t6_count",    count_o,    0);
      check("t6_entry",    entry_o,    0);
      check("t6_stall",    stall_o,    0);
      check("t6_overflow", overflow_o, 0);
`ifdef DECODE_QUEUE_HWM_EN
      check("t6_hwm", hwm_o, 0);
`endif
      @(negedge clock_i);
      reset_i = 1'b1;
      idle();

      // Random traffic with varying push/pop bias to reach full and empty.
      for (int blk = 0; blk < 20; blk++) begin
         int p_en;
         int p_rdy;
         p_en  = $urandom_range(10, 95);
         p_rdy = $urandom_range(10, 95);
         for (int c = 0; c < 100; c++) begin
            cycle($urandom_range(0, 99) < p_en,
                  $urandom_range(0, 99) < p_rdy,
                  $urandom_range(0, 63) == 0,
                  rand_entry());
         end
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
